// File: rtl/aes_bus_pkg.sv
// Shared types and constants for the AES register datapath (bus write side and read muxes).
package aes_bus_pkg;

    localparam int AES_DATA_W = 128;
    localparam int AES_R3_W   = 64;
    localparam int AES_HOST_W = 32;

    // Register select coding, common to busC writes and bus-A/B read muxes
    typedef enum logic [1:0] {SEL_R0, SEL_R1, SEL_R2, SEL_R3} reg_sel_t;

    // Host load sequencer states
    typedef enum logic {LD_IDLE, LD_LOAD} load_state_t;

    // Number of host words needed to fill a given register
    function automatic int words_for(reg_sel_t sel, int data_w, int r3_w, int host_w);
        return (sel == SEL_R3) ? (r3_w / host_w) : (data_w / host_w);
    endfunction

endpackage

// File: rtl/host_load_fsm.sv
// Host load sequencer: tracks target register, word index and completion pulse.
// Emits a word-write strobe; the register file itself lives in the top level.
module host_load_fsm
    import aes_bus_pkg::*;
#(
    parameter int DATA_W = AES_DATA_W,
    parameter int R3_W   = AES_R3_W,
    parameter int HOST_W = AES_HOST_W,
    parameter int CNT_W  = ((DATA_W / HOST_W) > 1) ? $clog2(DATA_W / HOST_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_start,
    input  reg_sel_t         host_sel,
    input  logic             host_valid,
    input  logic             we_busc,
    output logic             host_ready,
    output logic             load_busy,
    output logic             load_done,
    output logic             word_we,
    output reg_sel_t         tgt,
    output logic [CNT_W-1:0] word_idx
);

    load_state_t      state_q, state_d;
    reg_sel_t         tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;
    logic             last_word;

    // Next-state logic; a datapath write always stalls the host word
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        accept    = (state_q == LD_LOAD) && host_valid && !we_busc;
        last_word = (cnt_q == CNT_W'(words_for(tgt_q, DATA_W, R3_W, HOST_W) - 1));
        case (state_q)
            LD_IDLE: begin
                if (host_start) begin
                    tgt_d   = host_sel;
                    cnt_d   = '0;
                    state_d = LD_LOAD;
                end
            end
            LD_LOAD: begin
                if (accept) begin
                    if (last_word) begin
                        state_d = LD_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // Sequencer state; reset abandons any partial load without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
            tgt_q   <= SEL_R0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign host_ready = (state_q == LD_LOAD) && !we_busc;
    assign load_busy  = (state_q == LD_LOAD);
    assign load_done  = done_q;
    assign word_we    = accept;
    assign tgt        = tgt_q;
    assign word_idx   = cnt_q;

endmodule

// File: rtl/demux_busc.sv
// Write side of the AES register datapath: busC captures and host word loads into r0..r3.
module demux_busc
    import aes_bus_pkg::*;
#(
    parameter int DATA_W = AES_DATA_W,
    parameter int R3_W   = AES_R3_W,
    parameter int HOST_W = AES_HOST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] busC,
    input  logic [1:0]        SEL_busC,
    input  logic              WE_busC,
    input  logic              host_start,
    input  logic [1:0]        host_sel,
    input  logic [HOST_W-1:0] host_data,
    input  logic              host_valid,
    output logic              host_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [R3_W-1:0]   r3
);

    localparam int CNT_W = ((DATA_W / HOST_W) > 1) ? $clog2(DATA_W / HOST_W) : 1;

    logic [DATA_W-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
    logic [R3_W-1:0]   r3_q, r3_d;
    logic              word_we;
    reg_sel_t          tgt;
    logic [CNT_W-1:0]  word_idx;
    int                idx;

    host_load_fsm #(
        .DATA_W (DATA_W),
        .R3_W   (R3_W),
        .HOST_W (HOST_W),
        .CNT_W  (CNT_W)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .host_start (host_start),
        .host_sel   (reg_sel_t'(host_sel)),
        .host_valid (host_valid),
        .we_busc    (WE_busC),
        .host_ready (host_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .word_we    (word_we),
        .tgt        (tgt),
        .word_idx   (word_idx)
    );

    // Register writes: busC has priority; a host word fills its slice MSB-first
    always_comb begin
        r0_d = r0_q;
        r1_d = r1_q;
        r2_d = r2_q;
        r3_d = r3_q;
        idx  = int'(word_idx);
        if (WE_busC) begin
            case (reg_sel_t'(SEL_busC))
                SEL_R0:  r0_d = busC;
                SEL_R1:  r1_d = busC;
                SEL_R2:  r2_d = busC;
                default: r3_d = busC[R3_W-1:0];
            endcase
        end else if (word_we) begin
            case (tgt)
                SEL_R0:  r0_d[DATA_W-1-idx*HOST_W -: HOST_W] = host_data;
                SEL_R1:  r1_d[DATA_W-1-idx*HOST_W -: HOST_W] = host_data;
                SEL_R2:  r2_d[DATA_W-1-idx*HOST_W -: HOST_W] = host_data;
                default: r3_d[R3_W-1-idx*HOST_W -: HOST_W]   = host_data;
            endcase
        end
    end

    // Register file; cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_q <= '0;
            r1_q <= '0;
            r2_q <= '0;
            r3_q <= '0;
        end else begin
            r0_q <= r0_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
            r3_q <= r3_d;
        end
    end

    assign r0 = r0_q;
    assign r1 = r1_q;
    assign r2 = r2_q;
    assign r3 = r3_q;

endmodule

// File: tb/tb_demux_busc.sv
// Self-checking bench for demux_busc: directed and randomized busC/host traffic vs a register model.
module tb_demux_busc;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] busC;
    logic [1:0]   SEL_busC;
    logic         WE_busC;
    logic         host_start;
    logic [1:0]   host_sel;
    logic [31:0]  host_data;
    logic         host_valid;
    logic         host_ready, load_busy, load_done;
    logic [127:0] r0, r1, r2;
    logic [63:0]  r3;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected register contents (r3 kept zero-extended in slot 3)
    logic [127:0] m [4];

    demux_busc dut (
        .clk(clk), .rst(rst), .busC(busC), .SEL_busC(SEL_busC), .WE_busC(WE_busC),
        .host_start(host_start), .host_sel(host_sel), .host_data(host_data),
        .host_valid(host_valid), .host_ready(host_ready), .load_busy(load_busy),
        .load_done(load_done), .r0(r0), .r1(r1), .r2(r2), .r3(r3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".r0"}, r0, m[0]);
        check({tag, ".r1"}, r1, m[1]);
        check({tag, ".r2"}, r2, m[2]);
        check({tag, ".r3"}, {64'd0, r3}, m[3]);
    endtask

    function automatic int reg_width(input logic [1:0] sel);
        return (sel == 2'd3) ? 64 : 128;
    endfunction

    // Word k of a load fills bits [W-1-32k -: 32]
    function automatic logic [127:0] put_word(input logic [127:0] v, input int w, input int k,
                                              input logic [31:0] d);
        int           sh;
        logic [127:0] msk;
        sh  = w - 32 * (k + 1);
        msk = {96'd0, 32'hFFFF_FFFF} << sh;
        return (v & ~msk) | ({96'd0, d} << sh);
    endfunction

    task automatic dp_write(input logic [1:0] sel, input logic [127:0] val);
        @(negedge clk);
        WE_busC = 1'b1; SEL_busC = sel; busC = val;
        @(negedge clk);
        WE_busC = 1'b0;
        m[sel] = (sel == 2'd3) ? {64'd0, val[63:0]} : val;
    endtask

    // Full host load; optional random valid gaps, stray start, and a busC collision on word 1
    task automatic host_load(input logic [1:0] sel, input logic [31:0] w0, w1, w2, w3,
                             input bit gaps, input bit stray, input bit collide);
        logic [31:0] w [4];
        int  n, k, cyc;
        bit  collided, stray_done, we, acc;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        n = reg_width(sel) / 32;
        k = 0; cyc = 0; collided = 0; stray_done = 0;
        @(negedge clk);
        host_start = 1'b1; host_sel = sel;
        @(negedge clk);
        host_start = 1'b0; host_sel = 2'd0;
        check("load.busy_after_start", {127'd0, load_busy}, 128'd1);
        while (k < n && cyc < 200) begin
            cyc++;
            we         = collide && (k == 1) && !collided;
            WE_busC    = we;
            SEL_busC   = sel;
            busC       = '0;
            host_valid = we ? 1'b1 : (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
            host_data  = w[k];
            host_start = stray && (k == 1) && !stray_done;
            host_sel   = 2'd3;
            if (host_start) stray_done = 1;
            #1;
            check("load.host_ready", {127'd0, host_ready}, {127'd0, !we});
            acc = host_valid && !we;
            @(posedge clk);
            if (we) begin
                m[sel]   = '0;
                collided = 1;
            end
            if (acc) begin
                m[sel] = put_word(m[sel], reg_width(sel), k, w[k]);
                k++;
            end
            @(negedge clk);
        end
        WE_busC = 1'b0; host_valid = 1'b0; host_start = 1'b0; host_sel = 2'd0;
        check("load.words_accepted", 128'(k), 128'(n));
        check("load.done_pulse", {127'd0, load_done}, 128'd1);
        check("load.busy_cleared", {127'd0, load_busy}, 128'd0);
        @(negedge clk);
        check("load.done_single", {127'd0, load_done}, 128'd0);
    endtask

    initial begin
        rst = 1'b1; busC = '0; SEL_busC = '0; WE_busC = 1'b0;
        host_start = 1'b0; host_sel = '0; host_data = '0; host_valid = 1'b0;
        for (int i = 0; i < 4; i++) m[i] = '0;
        #12;
        check_regs("reset");
        check("reset.ready", {127'd0, host_ready}, 128'd0);
        check("reset.busy",  {127'd0, load_busy},  128'd0);
        check("reset.done",  {127'd0, load_done},  128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed datapath writes
        dp_write(2'd1, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        check_regs("dp_r1");
        dp_write(2'd3, 128'hFFFF_FFFF_FFFF_FFFF_0123_4567_89AB_CDEF);
        check("dp_r3.value", {64'd0, r3}, {64'd0, 64'h0123_4567_89AB_CDEF});
        check_regs("dp_r3");

        // Host valid while idle is ignored
        @(negedge clk);
        host_valid = 1'b1; host_data = 32'h5A5A_5A5A;
        #1;
        check("idle.host_ready", {127'd0, host_ready}, 128'd0);
        @(negedge clk);
        host_valid = 1'b0;
        check_regs("idle_valid");

        // Directed host loads
        host_load(2'd2, 32'h2B7E_1516, 32'h28AE_D2A6, 32'hABF7_1588, 32'h09CF_4F3C, 0, 0, 0);
        check("load_r2.value", r2, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
        check_regs("load_r2");
        host_load(2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 0, 0);
        check("load_r3.value", {64'd0, r3}, {64'd0, 64'hDEAD_BEEF_CAFE_F00D});
        check_regs("load_r3");

        // Collision on r0 load
        host_load(2'd0, 32'hAAAA_AAAA, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0, 0, 1);
        check("collide.value", r0, 128'h00000000_11111111_22222222_33333333);
        check_regs("collide");

        // Gaps with an ignored mid-load start
        host_load(2'd1, $urandom, $urandom, $urandom, $urandom, 1, 1, 0);
        check_regs("gaps_stray");

        // Randomized datapath writes and host loads
        for (int i = 0; i < 6; i++) begin
            dp_write(2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom});
            check_regs("rand_dp");
        end
        for (int i = 0; i < 4; i++) begin
            host_load(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                      1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_regs("rand_load");
        end

        // Reset in the middle of a load (after word 1 accepted)
        @(negedge clk);
        host_start = 1'b1; host_sel = 2'd0;
        @(negedge clk);
        host_start = 1'b0; host_valid = 1'b1; host_data = 32'h1234_5678;
        @(negedge clk);
        host_data = 32'h9ABC_DEF0;
        @(negedge clk);
        host_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) m[i] = '0;
        check_regs("midreset");
        check("midreset.busy", {127'd0, load_busy}, 128'd0);
        check("midreset.done", {127'd0, load_done}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postreset.done", {127'd0, load_done}, 128'd0);
        check("postreset.busy", {127'd0, load_busy}, 128'd0);
        check_regs("postreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
